bus_test_master: RTL and testbench
==================================

Name: bus_test_master

Overview:
- Synthesizable, parametrised successor to the behavioural read/write test processor.
- Runs a write-then-read-back sweep over a strobe/ready memory bus: writes NUM_WORDS locations, reads them back, compares, and reports a mismatch count plus pass/fail.
- Sits between a test controller (start/done) and any slave using the active-low strobe / active-low ready protocol.
- Adds per-access ready timeout and an optional inverted-pattern second pass.

Parameters:
- ADDR_W, 8, address bus width.
- DATA_W, 16, data bus width.
- NUM_WORDS, 10, locations per pass (1..2^ADDR_W).
- BASE_ADDR, 0, first address of the sweep.
- TIMEOUT, 15, wait cycles allowed per access before abort (>=1).
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to run the test; ignored while busy
- busy  out  1  high from the cycle after start is sampled until done
- done  out  1  sticky; high after the test completes, cleared by next accepted start or rst
- pass  out  1  valid while done: 1 iff err_count==0 and no timeouts
- err_count  out  ERR_W  mismatches plus timeouts, saturating
- timeout_seen  out  1  sticky; set by any aborted access
- addr  out  ADDR_W  bus address
- wdata  out  DATA_W  write data
- data_oe  out  1  write data drive enable (tri-state control at top level)
- rdata  in  DATA_W  read data
- rw  out  1  1=read, 0=write
- strb  out  1  active-low access strobe
- rdy  in  1  active-low slave ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; addr=0, wdata=0, data_oe=0, rw=0, strb=1, busy=0, done=0, pass=0, err_count=0, timeout_seen=0.
- A rst during any state aborts the current access at that edge: strb=1 and data_oe=0 on the next cycle.
- All outputs are registered.
- States:
  - IDLE: wait for start.
  - W_STRB -> W_WAIT for each write.
  - R_STRB -> R_WAIT for each read.
  - DONE.
- Start: start sampled high in IDLE or DONE.
  - Clears err_count, timeout_seen and done.
  - Sets busy and index=0, enters W_STRB.
- STRB state, exactly one cycle:
  - addr = BASE_ADDR+index, truncated to ADDR_W, so addresses wrap modulo 2^ADDR_W.
  - rw set for the access; strb=0.
  - Writes only: wdata = pattern(index), data_oe=1.
- WAIT state:
  - strb=1; addr, rw, wdata and data_oe held.
  - rdy is sampled at every posedge; rdy==0 completes the access.
  - On a read completion, rdata is captured and compared with pattern(index).
  - Minimum access = 2 cycles.
- Pattern: pattern(index) = index, zero-extended or truncated to DATA_W.
- Timeout: a wait counter resets on entry to WAIT. If TIMEOUT posedges pass with rdy!=0, the access is aborted:
  - err_count increments and timeout_seen is set.
  - An aborted read performs no compare.
  - The sequence continues with the next access.
- Mismatch: a completed read with rdata != pattern increments err_count.
- Saturation: err_count holds at 2^ERR_W-1.
- Sequencing:
  - After the last write (index==NUM_WORDS-1), index resets to 0 and the read pass starts.
  - After the last read, go to DONE: busy=0, done=1, pass=(err_count==0 && !timeout_seen).
  - data_oe is 0 for the whole read pass.
- start while busy is ignored.
- rdy low during a STRB cycle is ignored; it is only sampled in WAIT.

Optional Feature:
- Macro: BUS_TEST_INV_PASS_EN.
- Defined: after the first read pass, run a second write pass with pattern = ~index (DATA_W bits), then a second read pass comparing against ~index. Total accesses = 4*NUM_WORDS. Catches stuck-at-0 bits that the first pass misses.
- Undefined: two passes only (2*NUM_WORDS accesses); no extra state or logic.

Test Plan:
- Defaults, slave drives rdy=0 in every WAIT cycle:
  - start at posedge T0 -> strb low in [T0,T1).
  - done rises at T40.
  - pass=1, err_count=0.
  - Writes show data 0..9 at addr 0..9.
- Slave memory bit 0 stuck at 0 -> reads of odd indices mismatch -> err_count=5, pass=0.
- Slave never asserts rdy on address 3 writes/reads, TIMEOUT=15:
  - each aborted access lasts 1+15 cycles;
  - err_count=2, timeout_seen=1, pass=0;
  - the other 18 accesses complete normally.
- BASE_ADDR=8'hFC, NUM_WORDS=10 -> addresses FC,FD,FE,FF,00..05 with wrap; data 0..9; pass=1.
- rst pulsed during the 4th write's WAIT -> next cycle strb=1, data_oe=0, busy=0, all outputs at reset values. A fresh start then completes with pass=1.
- With BUS_TEST_INV_PASS_EN and a clean slave:
  - 40 accesses; second write pass data FFFF,FFFE,..,FFF6;
  - done at T80, pass=1.

Source files
------------

// File: rtl/bus_test_master.sv
// bus_test_master
//
// Synthesizable write-then-read-back test master for an active-low
// strobe / active-low ready memory bus. On start it writes pattern(index)
// to NUM_WORDS consecutive addresses beginning at BASE_ADDR. It then reads
// every location back and compares each one against the same pattern. It
// reports a saturating error count (mismatches plus ready timeouts) and a
// pass flag.
//
// Optional feature (compile-time macro BUS_TEST_INV_PASS_EN):
//   when defined, a second write/read sweep follows using the inverted
//   pattern ~index, so that stuck-at-0 bits the first sweep misses are seen.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   start        in   one-cycle request to run the test (ignored while busy)
//   busy         out  test in progress
//   done         out  sticky completion flag, cleared by next start or rst
//   pass         out  valid while done: no mismatches and no timeouts
//   err_count    out  mismatches plus timeouts, saturating
//   timeout_seen out  sticky, set by any aborted access
//   addr         out  bus address
//   wdata        out  write data
//   data_oe      out  write data drive enable
//   rdata        in   read data
//   rw           out  1 = read, 0 = write
//   strb         out  active-low access strobe
//   rdy          in   active-low slave ready
module bus_test_master #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int NUM_WORDS = 10,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 15,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              timeout_seen,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              data_oe,
    input  logic [DATA_W-1:0] rdata,
    output logic              rw,
    output logic              strb,
    input  logic              rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_STRB,
        S_W_WAIT,
        S_R_STRB,
        S_R_WAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam int                WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    // Pattern for a given index, optionally inverted for the second sweep.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] idx,
                                                  input logic inv);
        logic [DATA_W-1:0] p;
        p = DATA_W'(idx);
        return inv ? ~p : p;
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == '1) ? c : c + ERR_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              data_oe_q, data_oe_d;
    logic              rw_q, rw_d;
    logic              strb_q, strb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              tmo_q, tmo_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Which sweep is running: 0 = plain pattern, 1 = inverted pattern.
    logic              cur_inv;
`ifdef BUS_TEST_INV_PASS_EN
    logic              inv_q, inv_d;
    assign cur_inv = inv_q;
`else
    assign cur_inv = 1'b0;
`endif

    // Request to put the next access on the bus (STRB cycle outputs).
    logic              launch;
    logic              launch_rd;
    logic [ADDR_W-1:0] launch_idx;
    logic              launch_inv;
    logic              access_end;

    // Next-state logic. Every access is a one-cycle STRB followed by WAIT
    // cycles. The STRB outputs for the next access are registered at the
    // same edge that ends the previous access (or accepts start), so the
    // bus never has an idle cycle between back-to-back accesses.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_oe_d  = data_oe_q;
        rw_d       = rw_q;
        strb_d     = strb_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
`ifdef BUS_TEST_INV_PASS_EN
        inv_d      = inv_q;
`endif
        launch     = 1'b0;
        launch_rd  = 1'b0;
        launch_idx = idx_q;
        launch_inv = cur_inv;
        access_end = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d      = '0;
                    tmo_d      = 1'b0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    launch     = 1'b1;
                    launch_rd  = 1'b0;
                    launch_idx = '0;
                    launch_inv = 1'b0;
`ifdef BUS_TEST_INV_PASS_EN
                    inv_d      = 1'b0;
`endif
                end
            end
            S_W_STRB: begin
                state_d = S_W_WAIT;
                strb_d  = 1'b1;
                wait_d  = '0;
            end
            S_R_STRB: begin
                state_d = S_R_WAIT;
                strb_d  = 1'b1;
                wait_d  = '0;
            end
            S_W_WAIT, S_R_WAIT: begin
                // Ready wins over timeout when both happen on the same edge.
                if (!rdy) begin
                    access_end = 1'b1;
                    if ((state_q == S_R_WAIT) && (rdata != pattern(idx_q, cur_inv))) begin
                        err_d = sat_inc(err_q);
                    end
                end else if (wait_q == LAST_WAIT) begin
                    access_end = 1'b1;
                    err_d      = sat_inc(err_q);
                    tmo_d      = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end

                if (access_end) begin
                    if (idx_q != LAST_IDX) begin
                        launch     = 1'b1;
                        launch_rd  = (state_q == S_R_WAIT);
                        launch_idx = idx_q + ADDR_W'(1);
                    end else if (state_q == S_W_WAIT) begin
                        launch     = 1'b1;
                        launch_rd  = 1'b1;
                        launch_idx = '0;
`ifdef BUS_TEST_INV_PASS_EN
                    end else if (!inv_q) begin
                        launch     = 1'b1;
                        launch_rd  = 1'b0;
                        launch_idx = '0;
                        launch_inv = 1'b1;
                        inv_d      = 1'b1;
`endif
                    end else begin
                        state_d   = S_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        data_oe_d = 1'b0;
                        pass_d    = (err_d == '0) && !tmo_d;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            state_d   = launch_rd ? S_R_STRB : S_W_STRB;
            idx_d     = launch_idx;
            addr_d    = BASE + launch_idx;
            rw_d      = launch_rd;
            strb_d    = 1'b0;
            data_oe_d = !launch_rd;
            if (!launch_rd) begin
                wdata_d = pattern(launch_idx, launch_inv);
            end
        end
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_oe_q <= 1'b0;
            rw_q      <= 1'b0;
            strb_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            tmo_q     <= 1'b0;
            idx_q     <= '0;
            wait_q    <= '0;
`ifdef BUS_TEST_INV_PASS_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            data_oe_q <= data_oe_d;
            rw_q      <= rw_d;
            strb_q    <= strb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
`ifdef BUS_TEST_INV_PASS_EN
            inv_q     <= inv_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign timeout_seen = tmo_q;
    assign addr         = addr_q;
    assign wdata        = wdata_q;
    assign data_oe      = data_oe_q;
    assign rw           = rw_q;
    assign strb         = strb_q;

endmodule

// File: tb/tb_bus_test_master.sv
// tb_bus_test_master
//
// Drives bus_test_master against a behavioural slave memory with per-access
// ready latencies, optional stuck-at-0 read bits and stalled accesses. A
// reference model, written from the access plan, predicts the access
// sequence, the run length, the error count and the pass flag.
module tb_bus_test_master;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int NUM_WORDS = 10;
    localparam int BASE_ADDR = 'hFC;
    localparam int TIMEOUT   = 15;
    localparam int ERR_W     = 8;
`ifdef BUS_TEST_INV_PASS_EN
    localparam int PASSES    = 2;
`else
    localparam int PASSES    = 1;
`endif
    localparam int TOTAL     = 2 * NUM_WORDS * PASSES;
    localparam int NEVER     = 1000;
    localparam int MEM_SIZE  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic              oe;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic              timeout_seen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              data_oe;
    logic [DATA_W-1:0] rdata = '0;
    logic              rw;
    logic              strb;
    logic              rdy = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    bus_test_master #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .BASE_ADDR (BASE_ADDR),
        .TIMEOUT   (TIMEOUT),
        .ERR_W     (ERR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .timeout_seen (timeout_seen),
        .addr         (addr),
        .wdata        (wdata),
        .data_oe      (data_oe),
        .rdata        (rdata),
        .rw           (rw),
        .strb         (strb),
        .rdy          (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave state: access plan written by the stimulus, memory and
    // observed access records owned by the slave process.
    int                delays [0:TOTAL-1];
    logic [DATA_W-1:0] stuck0 = '0;
    logic [DATA_W-1:0] mem [0:MEM_SIZE-1];
    acc_t              obs [0:TOTAL-1];
    int                accIdx = 0;
    int                seenCount = 0;
    int                k = 0;
    int                curDelay = 0;
    logic              active = 1'b0;
    logic [ADDR_W-1:0] curAddr = '0;
    logic              curRw = 1'b0;
    logic [DATA_W-1:0] curWdata = '0;

    // Behavioural slave, working on the falling edge so that its view of
    // the DUT is stable and its rdy/rdata are settled before the next rise.
    always @(negedge clk) begin
        if (rst) begin
            for (int a = 0; a < MEM_SIZE; a++) mem[a] = DATA_W'($urandom);
        end
        if (!busy) begin
            accIdx = 0;
            active = 1'b0;
            rdy    = 1'b1;
        end else if (!strb) begin
            if (accIdx < TOTAL) begin
                obs[accIdx] = {addr, rw, data_oe, wdata};
                curDelay    = delays[accIdx];
            end else begin
                curDelay = 0;
            end
            accIdx    = accIdx + 1;
            seenCount = accIdx;
            curAddr   = addr;
            curRw     = rw;
            curWdata  = wdata;
            k         = 0;
            active    = 1'b1;
            rdy       = 1'($urandom_range(0, 1));
            rdata     = DATA_W'($urandom);
        end else if (active) begin
            if (k >= curDelay) begin
                rdy    = 1'b0;
                active = 1'b0;
                if (!curRw) mem[curAddr] = curWdata;
                else        rdata = mem[curAddr] & ~stuck0;
            end else begin
                rdy   = 1'b1;
                rdata = DATA_W'($urandom);
            end
            k = k + 1;
        end else begin
            rdy = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One full run. mode: 0 clean, 1 random latency + random stuck bit,
    // 2 index 3 never ready, 3 latencies up to past the timeout,
    // 4 clean latency with bit 0 stuck at 0. pokeAt > 0 pulses start
    // that many cycles into the run, which must be ignored.
    task automatic applyStimulus(input string tag, input int mode, input int pokeAt);
        logic [DATA_W-1:0] model [0:MEM_SIZE-1];
        acc_t              expAcc [0:TOTAL-1];
        acc_t              got;
        logic [DATA_W-1:0] pat;
        logic [ADDR_W-1:0] a;
        int                expLen, expErr, j, cycles, d;
        logic              expTmo, isRead;

        case (mode)
            1:       stuck0 = DATA_W'(1 << $urandom_range(0, DATA_W - 1));
            4:       stuck0 = DATA_W'(1);
            default: stuck0 = '0;
        endcase
        for (int n = 0; n < TOTAL; n++) begin
            case (mode)
                1:       d = $urandom_range(0, 4);
                2:       d = ((n % NUM_WORDS) == 3) ? NEVER : $urandom_range(0, 3);
                3:       d = $urandom_range(0, TIMEOUT + 4);
                default: d = 0;
            endcase
            delays[n] = d;
        end

        for (int m = 0; m < MEM_SIZE; m++) model[m] = mem[m];
        expLen = 0;
        expErr = 0;
        expTmo = 1'b0;
        for (int p = 0; p < PASSES; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    j      = (p * 2 + ph) * NUM_WORDS + i;
                    a      = ADDR_W'((BASE_ADDR + i) % MEM_SIZE);
                    pat    = DATA_W'(i);
                    if (p == 1) pat = ~pat;
                    isRead = (ph == 1);
                    expAcc[j] = {a, isRead, !isRead, isRead ? DATA_W'(0) : pat};
                    if (delays[j] < TIMEOUT) begin
                        expLen += delays[j] + 2;
                        if (!isRead) model[a] = pat;
                        else if ((model[a] & ~stuck0) != pat) expErr++;
                    end else begin
                        expLen += 1 + TIMEOUT;
                        expErr++;
                        expTmo = 1'b1;
                    end
                end
            end
        end
        if (expErr > (1 << ERR_W) - 1) expErr = (1 << ERR_W) - 1;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checkOutput({tag, "_t0_strb"}, 32'(strb), 32'(0));
        checkOutput({tag, "_t0_busy"}, 32'(busy), 32'(1));
        checkOutput({tag, "_t0_done"}, 32'(done), 32'(0));

        cycles = 0;
        while (!done && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            start = (cycles == pokeAt);
        end
        start = 1'b0;

        checkOutput({tag, "_done_cycle"}, 32'(cycles), 32'(expLen));
        checkOutput({tag, "_busy_end"}, 32'(busy), 32'(0));
        checkOutput({tag, "_err_count"}, 32'(err_count), 32'(expErr));
        checkOutput({tag, "_timeout_seen"}, 32'(timeout_seen), 32'(expTmo));
        checkOutput({tag, "_pass"}, 32'(pass), 32'((expErr == 0) && !expTmo));
        checkOutput({tag, "_accesses"}, 32'(seenCount), 32'(TOTAL));
        for (int n = 0; n < TOTAL; n++) begin
            got = obs[n];
            if (got.rw) got.wdata = '0;
            checkOutput($sformatf("%s_acc%0d", tag, n), 32'(got), 32'(expAcc[n]));
        end

        @(negedge clk);
        checkOutput({tag, "_done_sticky"}, 32'(done), 32'(1));
    endtask

    initial begin
        int seen;
        int guard;

        $display("[TB] bus_test_master bench, %0d accesses per run", TOTAL);
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("rst_busy",    32'(busy),         32'(0));
        checkOutput("rst_done",    32'(done),         32'(0));
        checkOutput("rst_pass",    32'(pass),         32'(0));
        checkOutput("rst_err",     32'(err_count),    32'(0));
        checkOutput("rst_tmo",     32'(timeout_seen), 32'(0));
        checkOutput("rst_addr",    32'(addr),         32'(0));
        checkOutput("rst_wdata",   32'(wdata),        32'(0));
        checkOutput("rst_data_oe", 32'(data_oe),      32'(0));
        checkOutput("rst_rw",      32'(rw),           32'(0));
        checkOutput("rst_strb",    32'(strb),         32'(1));

        applyStimulus("clean",      0, 0);
        applyStimulus("stuck_bit0", 4, 0);
        applyStimulus("stuck_rand", 1, 7);
        applyStimulus("stall_idx3", 2, 20);
        applyStimulus("timeouts",   3, 0);

        // Reset during the first WAIT cycle of the fourth write.
        for (int n = 0; n < TOTAL; n++) delays[n] = 2;
        stuck0 = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        seen  = 1;
        guard = 0;
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            if (!strb) seen++;
            else if (seen == 4) break;
        end
        checkOutput("abort_reached", 32'(seen), 32'(4));
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checkOutput("abort_strb",    32'(strb),         32'(1));
        checkOutput("abort_data_oe", 32'(data_oe),      32'(0));
        checkOutput("abort_busy",    32'(busy),         32'(0));
        checkOutput("abort_done",    32'(done),         32'(0));
        checkOutput("abort_pass",    32'(pass),         32'(0));
        checkOutput("abort_err",     32'(err_count),    32'(0));
        checkOutput("abort_tmo",     32'(timeout_seen), 32'(0));
        checkOutput("abort_addr",    32'(addr),         32'(0));
        checkOutput("abort_wdata",   32'(wdata),        32'(0));
        checkOutput("abort_rw",      32'(rw),           32'(0));
        repeat (2) @(negedge clk);

        applyStimulus("after_rst", 0, 0);
        for (int r = 0; r < 6; r++) begin
            applyStimulus($sformatf("rand%0d", r), 1 + (r % 3), r * 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
